// File: rtl/wb_master_bridge.sv
// Single-beat Wishbone B3 classic initiator: host valid/ready command in, one bus
// cycle out (with rty backoff and a no-response timeout), one response back.
module wb_master_bridge #(
  parameter int AW        = 32,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_adr,
  input  logic [31:0]   cmd_dat,
  input  logic [3:0]    cmd_sel,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_dat,
  output logic [1:0]    rsp_status,
  output logic [AW-1:0] wb_adr_o,
  output logic [31:0]   wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [31:0]   wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;
  localparam logic [1:0] ST_RTY = 2'b11;

  typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
  } req_t;

  typedef struct packed {
    logic [31:0] dat;
    logic [1:0]  status;
  } rsp_t;

  state_t      state, state_n;
  req_t        req_q, req_n;
  rsp_t        rsp_q, rsp_n;
  logic [3:0]  rty_q, rty_n;
  logic [15:0] to_q, to_n;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= IDLE;
      req_q <= '0;
      rsp_q <= '0;
      rty_q <= '0;
      to_q  <= '0;
    end else begin
      state <= state_n;
      req_q <= req_n;
      rsp_q <= rsp_n;
      rty_q <= rty_n;
      to_q  <= to_n;
    end
  end

  // Terminations are only looked at in BUS, so anything the slave drives while
  // cyc is low (late or stuck ack) has no effect.
  always_comb begin
    state_n = state;
    req_n   = req_q;
    rsp_n   = rsp_q;
    rty_n   = rty_q;
    to_n    = to_q;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          req_n   = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
          rty_n   = '0;
          to_n    = '0;
          state_n = BUS;
        end
      end
      BUS: begin
        if (wb_err_i) begin
          rsp_n   = '{dat: 32'h0, status: ST_ERR};
          state_n = RESP;
        end else if (wb_ack_i) begin
          rsp_n   = '{dat: (req_q.we ? 32'h0 : wb_dat_i), status: ST_OK};
          state_n = RESP;
        end else if (wb_rty_i) begin
          if (rty_q < 4'(MAX_RETRY)) begin
            rty_n   = rty_q + 4'd1;
            state_n = BACKOFF;
          end else begin
            rsp_n   = '{dat: 32'h0, status: ST_RTY};
            state_n = RESP;
          end
        end else if (to_q == 16'(TIMEOUT - 1)) begin
          // this is the TIMEOUT-th silent stb cycle
          rsp_n   = '{dat: 32'h0, status: ST_TMO};
          state_n = RESP;
        end else begin
          to_n = to_q + 16'd1;
        end
      end
      BACKOFF: begin
        to_n    = '0;
        state_n = BUS;
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Handshake and strobe outputs decode straight from state so reset clears them
  // without waiting for a clock.
  assign cmd_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign wb_cyc_o   = (state == BUS);
  assign wb_stb_o   = (state == BUS);
  assign rsp_dat    = rsp_q.dat;
  assign rsp_status = rsp_q.status;
  assign wb_adr_o   = req_q.adr;
  assign wb_dat_o   = req_q.dat;
  assign wb_sel_o   = req_q.sel;
  assign wb_we_o    = req_q.we;
  assign wb_cti_o   = 3'b000;
  assign wb_bte_o   = 2'b00;

endmodule

// File: doc/wb_master_bridge.md
# wb_master_bridge

Single-beat Wishbone B3 classic-cycle initiator. It turns commands from a host-side valid/ready port (UART/command decoder) into bus reads and writes toward the peripheral slaves (GPIO and others) and returns the data and status on a response port. It handles ack, err and rty terminations, bounded retry, and a no-response timeout, so a missing slave cannot hang the host path.

## Interface
- AW, 32, address width
- TIMEOUT, 255, cycles with cyc/stb high and no termination before abort (1..65535)
- MAX_RETRY, 3, rty terminations tolerated per command before giving up (0..15)

- wb_clk  in  1  clock
- wb_rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when both are high
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  AW  byte address
- cmd_dat  in  32  write data
- cmd_sel  in  4  byte lane enables
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both are high
- rsp_dat  out  32  read data; 0 for writes and failed reads
- rsp_status  out  2  00 ok, 01 err, 10 timeout, 11 retries exhausted
- wb_adr_o  out  AW, wb_dat_o  out  32, wb_sel_o  out  4, wb_we_o  out  1  registered command fields
- wb_cyc_o  out  1, wb_stb_o  out  1  always driven identically
- wb_cti_o  out  3  constant 000; wb_bte_o  out  2  constant 00
- wb_dat_i  in  32, wb_ack_i  in  1, wb_err_i  in  1, wb_rty_i  in  1

## Operation
- States: IDLE, BUS, BACKOFF, RESP.
- IDLE: cmd_ready=1 (combinational on state). On cmd_valid, register the command fields into wb_*_o, clear the retry and timeout counters, and go to BUS.
- BUS: cyc/stb=1. Terminations are sampled each rising edge. Priority is err > ack > rty.
  - err: status 01, rsp_dat=0, go to RESP.
  - ack: status 00. rsp_dat=wb_dat_i for a read, 0 for a write. Go to RESP.
  - rty: if the retry count < MAX_RETRY, increment it and go to BACKOFF. Otherwise status 11 and go to RESP.
  - No termination: increment the timeout counter. When it reaches TIMEOUT, set status 10 and go to RESP.
- BACKOFF: cyc/stb=0 for exactly one cycle. Clear the timeout counter and return to BUS with the same adr/dat/sel/we.
- RESP: cyc/stb=0 and rsp_valid=1. rsp_dat and rsp_status are held stable until rsp_ready, then go to IDLE.
- ack/err/rty are ignored whenever cyc is low.
- wb_adr_o, wb_dat_o, wb_sel_o and wb_we_o hold their values from acceptance until the next accepted command.

## Timing
- Reset values: all outputs 0 and state IDLE, except cmd_ready=1, which is a combinational decode of the IDLE reset state. Reset assertion takes effect immediately with no clock required.
- Reset asserted mid-transaction: cyc/stb drop immediately and the command is discarded. No response is produced.
- Command accepted at edge N:
  - cyc/stb high from cycle N+1.
  - With a slave that registers ack one cycle after stb, ack is high in N+2 and sampled at the end of N+2.
  - cyc/stb are low and rsp_valid is high in N+3.
  - With rsp_ready=1, cmd_ready is high in N+4. This gives a minimum of 4 cycles per command.
- A single-cycle ack pulse ends the cycle. cyc/stb are never high in the cycle after a sampled termination, which avoids a double-ack with slaves that toggle ack.
- Timeout counts cycles of BUS only. Abort occurs after exactly TIMEOUT cycles of stb with no termination, with status visible the cycle after.
- The retry count includes only rty terminations. The total number of bus attempts is at most MAX_RETRY+1.

## Test plan
- Write adr 0x0, dat 0xA5A5_00FF, sel 1111, slave acks one cycle after stb. Required:
  - wb_we_o=1 and the data/sel appear on the bus.
  - rsp_status 00, rsp_dat 0.
  - rsp_valid 3 cycles after acceptance.
- Read adr 0x4, slave returns 0x1234_5678 with ack. Required: rsp_dat 0x1234_5678, status 00, cyc high for exactly 2 cycles.
- Read with err and ack asserted together. Required: status 01, rsp_dat 0.
- MAX_RETRY=3, slave gives rty twice then ack. Required: three stb bursts, each separated by a one-cycle gap, then status 00. With four rty: four attempts, then status 11.
- TIMEOUT=8, slave silent. Required: cyc high for exactly 8 cycles, status 10, rsp_dat 0. A late ack after cyc falls is ignored.
- Hold rsp_ready=0 for 5 cycles with cmd_valid high. Required: rsp fields stable and cmd_ready=0 throughout. Then assert wb_rst_n=0 during a BUS cycle of the next command. Required: cyc/stb/rsp_valid go to 0 immediately and cmd_ready=1 after reset.
